reg_hazard_unit: RTL and testbench

REG_HAZARD_UNIT -- requirements
Module: reg_hazard_unit

---
 rtl/reg_hazard_unit.sv | 163 ++++++++++++++++
 tb/tb_reg_hazard_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_hazard_unit.sv
// reg_hazard_unit: ARMv8 register-field decoder with a scoreboard-based RAW
// hazard detector. Decoded fields are registered one cycle after acceptance.
// Optional macro HAZ_FWD_EN: assume full forwarding, so only a load in slot[0]
// whose destination is read by the incoming instruction causes a stall.
module reg_hazard_unit #(
    parameter int PIPE_DEPTH = 3,
    parameter int ZERO_REG   = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] inst,
    output logic        in_ready,
    output logic        out_valid,
    output logic [4:0]  rm_addr,
    output logic [4:0]  rn_addr,
    output logic [4:0]  rd_addr,
    output logic        rm_used,
    output logic        rn_used,
    output logic        rd_used,
    output logic        rd_write,
    output logic        stall
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

`ifdef HAZ_FWD_EN
    // Forwarding covers everything except a load result needed next cycle.
    localparam bit                    LOAD_ONLY  = 1'b1;
    localparam logic [PIPE_DEPTH-1:0] CHECK_MASK = {{(PIPE_DEPTH-1){1'b0}}, 1'b1};
`else
    // Every slot except the one writing back this cycle blocks a reader.
    localparam bit                    LOAD_ONLY  = 1'b0;
    localparam logic [PIPE_DEPTH-1:0] CHECK_MASK = {1'b0, {(PIPE_DEPTH-1){1'b1}}};
`endif

    logic dec_rn_used, dec_rm_used, dec_rd_used, dec_rd_write, dec_is_load;

    // Instruction class decode; classes are tested in priority order.
    always_comb begin
        dec_rn_used  = 1'b0;
        dec_rm_used  = 1'b0;
        dec_rd_used  = 1'b0;
        dec_rd_write = 1'b0;
        dec_is_load  = 1'b0;
        if (inst[31:25] == 7'b1101011) begin
            dec_rn_used = 1'b1;
        end else if (inst[28:26] == 3'b100) begin
            dec_rd_used  = 1'b1;
            dec_rd_write = 1'b1;
            case (inst[25:23])
                3'b010, 3'b011, 3'b100, 3'b110: dec_rn_used = 1'b1;
                3'b111: begin
                    dec_rn_used = 1'b1;
                    dec_rm_used = 1'b1;
                end
                default: ;
            endcase
        end else if (inst[29:28] == 2'b11 && !inst[25]) begin
            dec_rn_used  = 1'b1;
            dec_rd_used  = 1'b1;
            dec_rd_write = inst[22];
            dec_is_load  = inst[22];
            dec_rm_used  = !inst[24] && inst[21] && (inst[11:10] == 2'b10);
        end else if (inst[27:25] == 3'b101) begin
            dec_rn_used  = 1'b1;
            dec_rd_used  = 1'b1;
            dec_rd_write = 1'b1;
            if (!inst[28]) begin
                dec_rm_used = 1'b1;
            end else begin
                dec_rm_used = ((inst[24:21] == 4'b0110) && !inst[30])
                           || ((inst[24:21] == 4'b0000) && (inst[15:10] == 6'd0))
                           || ((inst[24:21] == 4'b0010) && !inst[11])
                           ||  (inst[24:21] == 4'b0100)
                           ||   inst[24];
            end
        end
    end

    // Live read sources: used and not the zero register. A store reads rd.
    logic src_rn_live, src_rm_live, src_rd_live;
    assign src_rn_live = dec_rn_used && (inst[9:5] != ZR);
    assign src_rm_live = dec_rm_used && (inst[20:16] != ZR);
    assign src_rd_live = dec_rd_used && !dec_rd_write && (inst[4:0] != ZR);

    logic                  slot_valid_reg [PIPE_DEPTH];
    logic                  slot_load_reg  [PIPE_DEPTH];
    logic [4:0]            slot_addr_reg  [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] slot_hit;
    logic                  hazard;
    logic                  accept;
    logic                  enter;

    assign hazard   = |(slot_hit & CHECK_MASK);
    assign in_ready = !reset && !hazard;
    assign accept   = in_valid && in_ready;
    assign stall    = in_valid && !in_ready;
    assign enter    = accept && dec_rd_write && (inst[4:0] != ZR);

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_slot
            assign slot_hit[gi] = slot_valid_reg[gi]
                && (slot_load_reg[gi] || !LOAD_ONLY)
                && ((src_rn_live && inst[9:5]   == slot_addr_reg[gi])
                 || (src_rm_live && inst[20:16] == slot_addr_reg[gi])
                 || (src_rd_live && inst[4:0]   == slot_addr_reg[gi]));

            if (gi == 0) begin : g_head
                // Slot 0 takes the accepted writer, or a bubble.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        slot_valid_reg[0] <= 1'b0;
                        slot_load_reg[0]  <= 1'b0;
                        slot_addr_reg[0]  <= '0;
                    end else begin
                        slot_valid_reg[0] <= enter;
                        slot_load_reg[0]  <= enter && dec_is_load;
                        slot_addr_reg[0]  <= enter ? inst[4:0] : 5'd0;
                    end
                end
            end else begin : g_body
                // Older slots simply advance one stage per cycle.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        slot_valid_reg[gi] <= 1'b0;
                        slot_load_reg[gi]  <= 1'b0;
                        slot_addr_reg[gi]  <= '0;
                    end else begin
                        slot_valid_reg[gi] <= slot_valid_reg[gi-1];
                        slot_load_reg[gi]  <= slot_load_reg[gi-1];
                        slot_addr_reg[gi]  <= slot_addr_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Registered decode outputs; non-accepted cycles present all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            rn_used   <= 1'b0;
            rm_used   <= 1'b0;
            rd_used   <= 1'b0;
            rd_write  <= 1'b0;
            rn_addr   <= '0;
            rm_addr   <= '0;
            rd_addr   <= '0;
        end else begin
            out_valid <= accept;
            rn_used   <= accept && dec_rn_used;
            rm_used   <= accept && dec_rm_used;
            rd_used   <= accept && dec_rd_used;
            rd_write  <= accept && dec_rd_write;
            rn_addr   <= (accept && dec_rn_used) ? inst[9:5]   : 5'd0;
            rm_addr   <= (accept && dec_rm_used) ? inst[20:16] : 5'd0;
            rd_addr   <= (accept && dec_rd_used) ? inst[4:0]   : 5'd0;
        end
    end

endmodule

// File: tb/tb_reg_hazard_unit.sv
// tb_reg_hazard_unit: directed and random stimulus for reg_hazard_unit,
// checked against a pending-write list model indexed by cycle age.
module tb_reg_hazard_unit;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] inst;
    logic        in_ready;
    logic        out_valid;
    logic [4:0]  rm_addr, rn_addr, rd_addr;
    logic        rm_used, rn_used, rd_used, rd_write;
    logic        stall;

    reg_hazard_unit #(.PIPE_DEPTH(DEPTH), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .inst(inst),
        .in_ready(in_ready), .out_valid(out_valid),
        .rm_addr(rm_addr), .rn_addr(rn_addr), .rd_addr(rd_addr),
        .rm_used(rm_used), .rn_used(rn_used), .rd_used(rd_used),
        .rd_write(rd_write), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rn_u, rm_u, rd_u, wr, ld;
        logic [4:0] rn, rm, rd;
    } dec_t;

    typedef struct {
        int reg_idx;
        bit is_load;
        int cyc;
    } pend_t;

    pend_t pend[$];
    int    cyc_now   = 0;
    int    vectors   = 0;
    int    n_checks  = 0;
    int    errs      = 0;
    dec_t  exp_out;
    bit    exp_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        assert (got === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Reference decode written from the class rules.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        d = '0;
        if (w[31:25] == 7'b1101011) begin
            d.rn_u = 1'b1;
        end else if (w[28:26] == 3'b100) begin
            d.wr = 1'b1; d.rd_u = 1'b1;
            d.rn_u = (w[25:23] inside {3'b010, 3'b011, 3'b100, 3'b110, 3'b111});
            d.rm_u = (w[25:23] == 3'b111);
        end else if (w[29:28] == 2'b11 && w[25] == 1'b0) begin
            d.rn_u = 1'b1; d.rd_u = 1'b1;
            d.wr = w[22]; d.ld = w[22];
            d.rm_u = (w[24] == 1'b0) && (w[21] == 1'b1) && (w[11:10] == 2'b10);
        end else if (w[27:25] == 3'b101) begin
            d.rn_u = 1'b1; d.rd_u = 1'b1; d.wr = 1'b1;
            if (w[28] == 1'b0) d.rm_u = 1'b1;
            else begin
                case (w[24:21])
                    4'b0110: d.rm_u = (w[30] == 1'b0);
                    4'b0000: d.rm_u = (w[15:10] == 6'd0);
                    4'b0010: d.rm_u = (w[11] == 1'b0);
                    4'b0100: d.rm_u = 1'b1;
                    default: d.rm_u = w[24];
                endcase
            end
        end
        d.rn = d.rn_u ? w[9:5]   : 5'd0;
        d.rm = d.rm_u ? w[20:16] : 5'd0;
        d.rd = d.rd_u ? w[4:0]   : 5'd0;
        return d;
    endfunction

    // A pending write of age a (cycles since acceptance) blocks readers
    // when 1 <= a <= DEPTH-1; with forwarding only a load of age 1 blocks.
    function automatic bit model_haz(input dec_t d);
        bit h;
        int age;
        h = 1'b0;
        foreach (pend[k]) begin
            age = cyc_now - pend[k].cyc;
`ifdef HAZ_FWD_EN
            if (age == 1 && pend[k].is_load) begin
`else
            if (age >= 1 && age <= DEPTH - 1) begin
`endif
                if (d.rn_u && d.rn != 5'd31 && int'(d.rn) == pend[k].reg_idx) h = 1'b1;
                if (d.rm_u && d.rm != 5'd31 && int'(d.rm) == pend[k].reg_idx) h = 1'b1;
                if (d.rd_u && !d.wr && d.rd != 5'd31 && int'(d.rd) == pend[k].reg_idx) h = 1'b1;
            end
        end
        return h;
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
    task automatic apply(input logic rst, input logic v, input logic [31:0] w,
                         output bit acc, output bit ds);
        dec_t d;
        bit   exp_ready, exp_stall;
        reset = rst; in_valid = v; inst = w;
        #1;
        d = ref_decode(w);
        exp_ready = !rst && !model_haz(d);
        exp_stall = v && !exp_ready;
        vectors++;
        ds = stall;
        check("stall", 32'(stall), 32'(exp_stall));
        if (v) check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        cyc_now++;
        if (rst) begin
            pend.delete();
            exp_v = 1'b0;
            exp_out = '0;
        end else begin
            if (acc && d.wr && d.rd != 5'd31)
                pend.push_back('{reg_idx: int'(d.rd), is_load: bit'(d.ld), cyc: cyc_now - 1});
            exp_v = acc;
            exp_out = acc ? d : '0;
        end
        while (pend.size() > 0 && cyc_now - pend[0].cyc >= DEPTH) void'(pend.pop_front());
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v || rst) begin
            check("rn_used",  32'(rn_used),  32'(exp_out.rn_u));
            check("rm_used",  32'(rm_used),  32'(exp_out.rm_u));
            check("rd_used",  32'(rd_used),  32'(exp_out.rd_u));
            check("rd_write", 32'(rd_write), 32'(exp_out.wr));
            check("rn_addr",  32'(rn_addr),  32'(exp_out.rn));
            check("rm_addr",  32'(rm_addr),  32'(exp_out.rm));
            check("rd_addr",  32'(rd_addr),  32'(exp_out.rd));
        end
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0: w[31:25] = 7'b1101011;
            1: w[28:26] = 3'b100;
            2: begin w[29:28] = 2'b11; w[25] = 1'b0; end
            3: w[27:25] = 3'b101;
            default: ;
        endcase
        w[4:0]   = pick_reg();
        w[9:5]   = pick_reg();
        w[20:16] = pick_reg();
        return w;
    endfunction

    localparam logic [31:0] ADD1 = 32'h8B030041;
    localparam logic [31:0] ADD2 = 32'h8B050024;

    initial begin
        bit acc, ds, hold, rs, cv;
        int n, guard;
        logic [31:0] cur;
        reset = 1'b1; in_valid = 1'b0; inst = '0;
        @(posedge clk);
        #1;

        // Reset state, with an instruction offered: in_ready held low.
        apply(1'b1, 1'b1, ADD1, acc, ds);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        apply(1'b0, 1'b0, 32'd0, acc, ds);

        // Dependent ADD pair: two stall cycles, then accepted.
        apply(1'b0, 1'b1, ADD1, acc, ds);
        n = 0; guard = 0;
        do begin
            apply(1'b0, 1'b1, ADD2, acc, ds);
            n += int'(ds); guard++;
        end while (ds && guard < 10);
        check("pair_stall_cycles", 32'(n), 32'd2);
        check("pair_rn", 32'(rn_addr), 32'd1);
        check("pair_rm", 32'(rm_addr), 32'd5);
        check("pair_rd", 32'(rd_addr), 32'd4);
        apply(1'b0, 1'b0, 32'd0, acc, ds);
        apply(1'b0, 1'b0, 32'd0, acc, ds);

        // Reset during stall drops the hazard.
        apply(1'b0, 1'b1, ADD1, acc, ds);
        apply(1'b0, 1'b1, ADD2, acc, ds);
        check("pre_reset_stall", 32'(ds), 32'd1);
        apply(1'b1, 1'b1, ADD2, acc, ds);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        apply(1'b0, 1'b1, ADD2, acc, ds);
        check("post_reset_no_stall", 32'(ds), 32'd0);
        check("post_reset_out_valid", 32'(out_valid), 32'd1);

        // Zero-register destination never blocks; rm=31 is still reported.
        apply(1'b0, 1'b1, 32'h8B03005F, acc, ds);
        apply(1'b0, 1'b1, 32'h8B1F0024, acc, ds);
        check("xzr_no_stall", 32'(ds), 32'd0);
        check("xzr_rm_used", 32'(rm_used), 32'd1);
        check("xzr_rm_addr", 32'(rm_addr), 32'd31);

        // BR X30.
        apply(1'b0, 1'b1, 32'hD61F03C0, acc, ds);
        check("br_valid", 32'(out_valid), 32'd1);
        check("br_rn_used", 32'(rn_used), 32'd1);
        check("br_rn_addr", 32'(rn_addr), 32'd30);
        check("br_rd_write", 32'(rd_write), 32'd0);

`ifdef HAZ_FWD_EN
        apply(1'b1, 1'b0, 32'd0, acc, ds);
        apply(1'b0, 1'b1, ADD1, acc, ds);
        apply(1'b0, 1'b1, ADD2, acc, ds);
        check("fwd_pair_no_stall", 32'(ds), 32'd0);
        apply(1'b0, 1'b1, 32'hF8400041, acc, ds);
        n = 0; guard = 0;
        do begin
            apply(1'b0, 1'b1, ADD2, acc, ds);
            n += int'(ds); guard++;
        end while (ds && guard < 10);
        check("fwd_load_use_stalls", 32'(n), 32'd1);
`endif

        // Random traffic; a stalled instruction is held until accepted.
        hold = 1'b0; cur = '0; cv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 99) < 2);
            if (!hold) begin
                cv  = ($urandom_range(0, 9) != 0);
                cur = gen_inst();
            end
            apply(rs, cv, cur, acc, ds);
            hold = cv && !acc && !rs;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
